// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stall/bubble generator with multi-cycle bubbles, branch flush,
// debug freeze via hold registers and a saturating stall-cycle counter.
module hazard_stall_controller #(
  parameter int CANT_BITS_ADDR_REGISTROS = 5,
  parameter int LOAD_LATENCY             = 1,
  parameter int CANT_BITS_STATS          = 16
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_enable_etapa,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rs_id,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rt_id,
  input  logic                                i_uses_rt_id,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_registro_destino_ex,
  input  logic                                i_read_mem_ex,
  input  logic                                i_disable_for_exception,
  input  logic                                i_branch_taken_id,
  input  logic                                i_clear_stats,
  output logic                                o_stall,
  output logic                                o_bit_burbuja,
  output logic                                o_flush_if_id,
  output logic                                o_led,
  output logic [CANT_BITS_STATS-1:0]          o_stall_count
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [CANT_BITS_STATS-1:0] count_q, count_d;
  logic                       stall_hold_q, flush_hold_q, led_hold_q;
  logic                       hz, stall_c, flush_c;
  assign hz = i_read_mem_ex & (i_registro_destino_ex != '0)
            & ((i_registro_destino_ex == i_rs_id) | (i_uses_rt_id & (i_registro_destino_ex == i_rt_id)))
            & ~i_disable_for_exception;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = hz;
    flush_c = i_branch_taken_id & ~hz & ~i_disable_for_exception;
    if (state_q == STALL) begin
      stall_c = ~i_disable_for_exception;
      flush_c = 1'b0;
      if (i_disable_for_exception) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else if (cnt_q == 4'd1) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (hz && LOAD_LATENCY > 1) begin
      state_d = STALL;
      cnt_d   = 4'(LOAD_LATENCY - 1);
    end
  end
  assign count_d = i_clear_stats ? '0
                 : (stall_c && !(&count_q)) ? count_q + {{(CANT_BITS_STATS-1){1'b0}}, 1'b1}
                 : count_q;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      count_q      <= '0;
      stall_hold_q <= 1'b0;
      flush_hold_q <= 1'b0;
      led_hold_q   <= 1'b1;
    end else if (i_enable_etapa) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      stall_hold_q <= stall_c;
      flush_hold_q <= flush_c;
      led_hold_q   <= ~stall_c;
    end
  end
  // reset overrides the combinational path so outputs are clean while reset is held
  assign o_stall       = !i_reset ? 1'b0 : i_enable_etapa ? stall_c  : stall_hold_q;
  assign o_bit_burbuja = !i_reset ? 1'b0 : i_enable_etapa ? stall_c  : stall_hold_q;
  assign o_flush_if_id = !i_reset ? 1'b0 : i_enable_etapa ? flush_c  : flush_hold_q;
  assign o_led         = !i_reset ? 1'b1 : i_enable_etapa ? ~stall_c : led_hold_q;
  assign o_stall_count = count_q;
endmodule
